// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory boot loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - packs little-endian stream bytes into 32-bit words
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        lane_last,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [1:0]                         lane;
  logic [BYTES_PER_WORD-2:0][7:0]     asm_q;

  assign lane_last = (lane == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      lane       <= '0;
      asm_q      <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        lane <= '0;
      end else if (byte_valid) begin
        // The top byte is never stored; it goes straight into the output word.
        if (lane_last) begin
          word_valid <= 1'b1;
          word_data  <= {byte_data, asm_q};
          lane       <= '0;
        end else begin
          asm_q[lane] <= byte_data;
          lane        <= lane + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads instruction memory from a length-prefixed byte stream, then releases core reset
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic          reload,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          cpu_rst_n,
  output logic          done,
  output logic          error
);

  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  state_t      state;
  logic [7:0]  n_lo;
  logic [AW:0] n_words;
  logic [AW:0] index;
  logic [15:0] n_full;
  logic        accept;
  logic        lane_last;

  assign n_full   = {in_data, n_lo};
  assign in_ready = !rst && (state == S_HDR0 || state == S_HDR1 || state == S_DATA);
  assign accept   = in_valid && in_ready;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (state != S_DATA),
    .byte_valid (accept && state == S_DATA),
    .byte_data  (in_data),
    .lane_last  (lane_last),
    .word_valid (wr_en),
    .word_data  (wr_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_HDR0;
      n_lo      <= '0;
      n_words   <= '0;
      index     <= '0;
      wr_addr   <= '0;
      cpu_rst_n <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        S_HDR0: if (accept) begin
          n_lo  <= in_data;
          state <= S_HDR1;
        end
        S_HDR1: if (accept) begin
          index <= '0;
          if (n_full == 16'd0)         state <= S_DRAIN;
          else if (n_full > DEPTH16)   state <= S_ERROR;
          else begin
            n_words <= n_full[AW:0];
            state   <= S_DATA;
          end
        end
        S_DATA: if (accept && lane_last) begin
          // Address is registered alongside the packer's word so both appear together.
          wr_addr <= index[AW-1:0];
          index   <= index + (AW+1)'(1);
          if (index == n_words - (AW+1)'(1)) state <= S_DRAIN;
        end
        S_DRAIN: state <= S_DONE;
        S_DONE: begin
          if (reload) begin
            state     <= S_HDR0;
            done      <= 1'b0;
            cpu_rst_n <= 1'b0;
          end else begin
            done      <= 1'b1;
            cpu_rst_n <= 1'b1;
          end
        end
        S_ERROR: begin
          if (reload) begin
            state <= S_HDR0;
            error <= 1'b0;
          end else begin
            error <= 1'b1;
          end
        end
        default: state <= S_HDR0;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader with a word-level reference model
module tb_imem_loader;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          reload;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_rst_n;
  logic          done;
  logic          error;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .reload    (reload),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_rst_n (cpu_rst_n),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          bad_strobe = 0;
  logic [31:0] exp_mem [DEPTH];
  logic [31:0] dut_mem [DEPTH];
  logic [31:0] words   [DEPTH];
  int          got_addr [$];
  logic [31:0] got_data [$];
  logic        acc_prev = 1'b0;
  logic        wr_prev  = 1'b0;

  // Passive monitor: captures every write and flags strobes that are not the
  // cycle right after an accepted byte, or that last longer than one cycle.
  always @(posedge clk) acc_prev <= in_valid && in_ready;

  always @(negedge clk) begin
    if (wr_en) begin
      got_addr.push_back(int'(wr_addr));
      got_data.push_back(wr_data);
      dut_mem[wr_addr] <= wr_data;
      if (!acc_prev || wr_prev) bad_strobe <= bad_strobe + 1;
    end
    wr_prev <= wr_en;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      int g;
      g = int'($urandom_range(0, 3));
      for (int i = 0; i < g; i++) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_for_byte", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Builds the stream from the word list, sends it, then checks release timing
  // and the exact sequence of writes against the model.
  task automatic run_load(input int n, input bit gaps);
    logic [7:0] s [$];
    s.push_back(8'(n));
    s.push_back(8'(n >> 8));
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 4; j++)
        s.push_back(8'(words[i] >> (8 * j)));
    got_addr.delete();
    got_data.delete();
    foreach (s[i]) send_byte(s[i], gaps);
    check("rstn_at_k", 32'(cpu_rst_n), 32'd0);
    check("done_at_k", 32'(done), 32'd0);
    if (n > 0) check("strobe_after_last", 32'(wr_en), 32'd1);
    @(negedge clk);
    check("done_at_k1", 32'(done), 32'd0);
    check("rstn_at_k1", 32'(cpu_rst_n), 32'd0);
    check("strobe_one_cycle", 32'(wr_en), 32'd0);
    @(negedge clk);
    check("done_at_k2", 32'(done), 32'd1);
    check("rstn_at_k2", 32'(cpu_rst_n), 32'd1);
    check("ready_in_done", 32'(in_ready), 32'd0);
    check("write_count", 32'(got_addr.size()), 32'(n));
    for (int i = 0; i < n && i < got_addr.size(); i++) begin
      check("write_addr", 32'(got_addr[i]), 32'(i));
      check("write_data", got_data[i], words[i]);
    end
    for (int i = 0; i < n; i++) exp_mem[i] = words[i];
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("reload_rstn", 32'(cpu_rst_n), 32'd0);
    check("reload_done", 32'(done), 32'd0);
    check("reload_error", 32'(error), 32'd0);
    check("reload_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_mem[i] = 32'h0;
      dut_mem[i] = 32'h0;
    end
    @(negedge clk);
    @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);
    @(negedge clk);

    words[0] = 32'h00500113;
    words[1] = 32'h00210233;
    run_load(2, 1'b0);

    do_reload();
    run_load(0, 1'b0);

    // Oversized header: loader must lock up in ERROR and ignore further bytes.
    do_reload();
    got_addr.delete();
    send_byte(8'h21, 1'b0);
    send_byte(8'h00, 1'b0);
    check("err_ready_at_k", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("err_flag", 32'(error), 32'd1);
    check("err_rstn", 32'(cpu_rst_n), 32'd0);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("err_ready_held", 32'(in_ready), 32'd0);
    check("err_no_writes", 32'(got_addr.size()), 32'd0);
    check("err_held", 32'(error), 32'd1);
    do_reload();

    for (int i = 0; i < 3; i++) words[i] = $urandom;
    run_load(3, 1'b1);
    do_reload();
    run_load(3, 1'b0);

    do_reload();
    words[0] = 32'hFFF00113;
    run_load(1, 1'b0);

    // Reset two bytes into word 1: word 0 lands, the partial word must not.
    do_reload();
    words[0] = $urandom;
    words[1] = $urandom;
    got_addr.delete();
    got_data.delete();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int j = 0; j < 4; j++) send_byte(8'(words[0] >> (8 * j)), 1'b0);
    for (int j = 0; j < 2; j++) send_byte(8'(words[1] >> (8 * j)), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_writes", 32'(got_addr.size()), 32'd1);
    if (got_data.size() > 0) check("midrst_word0", got_data[0], words[0]);
    exp_mem[0] = words[0];
    words[0] = $urandom;
    run_load(1, 1'b0);

    for (int r = 0; r < 4; r++) begin
      do_reload();
      n = (r == 0) ? DEPTH : int'($urandom_range(1, DEPTH));
      for (int i = 0; i < n; i++) words[i] = $urandom;
      run_load(n, bit'($urandom_range(0, 1)));
    end

    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) check("mem_contents", dut_mem[i], exp_mem[i]);
    check("strobe_shape", 32'(bad_strobe), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
